// File: rtl/purisc_trace_pkg.sv
// Shared types and record layout for the PURISC golden-trace lockstep checker.
package purisc_trace_pkg;

    // One record holds 12 data-width fields plus the single write-enable bit.
    function automatic int rec_w(input int data_w);
        return 12 * data_w + 1;
    endfunction

    localparam int NUM_FIELDS = 13;

    typedef enum logic [3:0] {
        F_R_ADDR_A     = 4'd0,
        F_R_ADDR_B     = 4'd1,
        F_R_ADDR_C     = 4'd2,
        F_R_ADDR_0     = 4'd3,
        F_R_ADDR_1     = 4'd4,
        F_R_DATA_A     = 4'd5,
        F_R_DATA_B     = 4'd6,
        F_R_DATA_C     = 4'd7,
        F_R_DATA_0     = 4'd8,
        F_R_DATA_1     = 4'd9,
        F_W_ADDR       = 4'd10,
        F_W_DATA       = 4'd11,
        F_WE           = 4'd12,
        FIELD_UNDERRUN = 4'd15
    } field_e;

    // Bit offset of a field inside a record; field 12 (we) is one bit wide.
    function automatic int field_off(input int field, input int data_w);
        return field * data_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO holding expected trace records; no full-FIFO bypass.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; flush discards all stored records.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/trace_lockstep_checker.sv
// Golden-trace lockstep checker: compares each core's live bus against queued records.
module trace_lockstep_checker
    import purisc_trace_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    localparam int REC_W     = rec_w(DATA_W)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       START,
    input  logic                       ABORT,
    input  logic [NUM_CORES-1:0]       EXP_VALID,
    input  logic [NUM_CORES-1:0]       EXP_LAST,
    input  logic [NUM_CORES*REC_W-1:0] EXP_REC,
    output logic [NUM_CORES-1:0]       EXP_READY,
    input  logic [NUM_CORES*REC_W-1:0] OBS_REC,
    input  logic [NUM_CORES-1:0]       OBS_STALL,
    output logic [NUM_CORES*CNT_W-1:0] CYCLE_COUNT,
    output logic [NUM_CORES*CNT_W-1:0] MISMATCH_COUNT,
    output logic [NUM_CORES-1:0]       UNDERRUN,
    output logic                       FIRST_ERR_VALID,
    output logic [2:0]                 FIRST_ERR_CORE,
    output logic [CNT_W-1:0]           FIRST_ERR_CYCLE,
    output logic [3:0]                 FIRST_ERR_FIELD,
    output logic                       DONE,
    output logic                       PASS
);

    state_e                 state_q, state_d;
    logic                   start_go;
    logic [NUM_CORES-1:0]   fifo_empty, fifo_full, fifo_pop;
    logic [NUM_CORES-1:0]   demand, underrun_now, mism_now, err_now, finish_now;
    logic [NUM_CORES-1:0]   finished_q, underrun_q;
    logic [REC_W:0]         fifo_dout [NUM_CORES];
    logic [3:0]             err_field [NUM_CORES];
    logic [CNT_W-1:0]       cyc_q [NUM_CORES];
    logic [CNT_W-1:0]       mis_q [NUM_CORES];
    logic                   fe_valid_q, fe_hit;
    logic [2:0]             fe_core_q, fe_core_d;
    logic [CNT_W-1:0]       fe_cycle_q, fe_cycle_d;
    logic [3:0]             fe_field_q, fe_field_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [NUM_FIELDS-1:0] field_diff(input logic [REC_W-1:0] e,
                                                         input logic [REC_W-1:0] o);
        logic [NUM_FIELDS-1:0] d;
        for (int i = 0; i < NUM_FIELDS - 1; i++)
            d[i] = e[field_off(i, DATA_W) +: DATA_W] != o[field_off(i, DATA_W) +: DATA_W];
        d[NUM_FIELDS-1] = e[REC_W-1] != o[REC_W-1];
        return d;
    endfunction

    function automatic logic [3:0] lowest_field(input logic [NUM_FIELDS-1:0] d);
        logic [3:0] f;
        f = FIELD_UNDERRUN;
        for (int i = NUM_FIELDS - 1; i >= 0; i--)
            if (d[i]) f = 4'(i);
        return f;
    endfunction

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        logic [NUM_FIELDS-1:0] diff;

        trace_fifo #(.WIDTH(REC_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (CLK),
            .rst   (RESET),
            .flush (ABORT),
            .push  (EXP_VALID[k]),
            .din   ({EXP_LAST[k], EXP_REC[k*REC_W +: REC_W]}),
            .pop   (fifo_pop[k]),
            .dout  (fifo_dout[k]),
            .empty (fifo_empty[k]),
            .full  (fifo_full[k])
        );

        assign demand[k]       = (state_q == ST_RUN) & ~ABORT & ~finished_q[k] & ~OBS_STALL[k];
        assign fifo_pop[k]     = demand[k] & ~fifo_empty[k];
        assign underrun_now[k] = demand[k] & fifo_empty[k];
        assign diff            = field_diff(fifo_dout[k][REC_W-1:0], OBS_REC[k*REC_W +: REC_W]);
        assign mism_now[k]     = fifo_pop[k] & (|diff);
        assign err_now[k]      = mism_now[k] | underrun_now[k];
        assign err_field[k]    = underrun_now[k] ? FIELD_UNDERRUN : lowest_field(diff);
        assign finish_now[k]   = fifo_pop[k] & fifo_dout[k][REC_W];

        assign EXP_READY[k]                    = ~fifo_full[k];
        assign CYCLE_COUNT[k*CNT_W +: CNT_W]    = cyc_q[k];
        assign MISMATCH_COUNT[k*CNT_W +: CNT_W] = mis_q[k];
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: ABORT wins over START; START only honoured when not running.
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d  = ST_RUN;
                        start_go = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (&(finished_q | finish_now)) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Per-core saturating counters and sticky finished/underrun flags.
    always_ff @(posedge CLK) begin
        if (RESET || start_go) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                cyc_q[k] <= '0;
                mis_q[k] <= '0;
            end
            finished_q <= '0;
            underrun_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (fifo_pop[k]) cyc_q[k] <= sat_inc(cyc_q[k]);
                if (err_now[k])  mis_q[k] <= sat_inc(mis_q[k]);
            end
            finished_q <= finished_q | finish_now;
            underrun_q <= underrun_q | underrun_now;
        end
    end

    // Priority encoder: lowest-index erroring core this cycle.
    always_comb begin
        fe_hit     = 1'b0;
        fe_core_d  = '0;
        fe_cycle_d = '0;
        fe_field_d = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (err_now[k]) begin
                fe_hit     = 1'b1;
                fe_core_d  = 3'(k);
                fe_cycle_d = cyc_q[k];
                fe_field_d = err_field[k];
            end
        end
    end

    // First-error capture, frozen once valid until the next START.
    always_ff @(posedge CLK) begin
        if (RESET || start_go) begin
            fe_valid_q <= 1'b0;
            fe_core_q  <= '0;
            fe_cycle_q <= '0;
            fe_field_q <= '0;
        end else if (!fe_valid_q && fe_hit) begin
            fe_valid_q <= 1'b1;
            fe_core_q  <= fe_core_d;
            fe_cycle_q <= fe_cycle_d;
            fe_field_q <= fe_field_d;
        end
    end

    assign UNDERRUN        = underrun_q;
    assign FIRST_ERR_VALID = fe_valid_q;
    assign FIRST_ERR_CORE  = fe_core_q;
    assign FIRST_ERR_CYCLE = fe_cycle_q;
    assign FIRST_ERR_FIELD = fe_field_q;
    assign DONE            = (state_q == ST_DONE);
    assign PASS            = DONE & ~fe_valid_q;

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Directed bench for trace_lockstep_checker with 2 cores, 32-bit data, depth-8 FIFOs.
module tb_trace_lockstep_checker;

    localparam int NC    = 2;
    localparam int DW    = 32;
    localparam int RW    = 12 * DW + 1;
    localparam int CW    = 16;

    logic             Clock_50;
    logic             RESET, START, ABORT;
    logic [NC-1:0]    EXP_VALID, EXP_LAST, EXP_READY, OBS_STALL, UNDERRUN;
    logic [NC*RW-1:0] EXP_REC, OBS_REC;
    logic [NC*CW-1:0] CYCLE_COUNT, MISMATCH_COUNT;
    logic             FIRST_ERR_VALID, DONE, PASS;
    logic [2:0]       FIRST_ERR_CORE;
    logic [CW-1:0]    FIRST_ERR_CYCLE;
    logic [3:0]       FIRST_ERR_FIELD;

    int checks = 0;
    int errors = 0;

    trace_lockstep_checker #(.NUM_CORES(NC), .DATA_W(DW), .FIFO_DEPTH(8), .CNT_W(CW)) dut (
        .CLK             (Clock_50),
        .RESET           (RESET),
        .START           (START),
        .ABORT           (ABORT),
        .EXP_VALID       (EXP_VALID),
        .EXP_LAST        (EXP_LAST),
        .EXP_REC         (EXP_REC),
        .EXP_READY       (EXP_READY),
        .OBS_REC         (OBS_REC),
        .OBS_STALL       (OBS_STALL),
        .CYCLE_COUNT     (CYCLE_COUNT),
        .MISMATCH_COUNT  (MISMATCH_COUNT),
        .UNDERRUN        (UNDERRUN),
        .FIRST_ERR_VALID (FIRST_ERR_VALID),
        .FIRST_ERR_CORE  (FIRST_ERR_CORE),
        .FIRST_ERR_CYCLE (FIRST_ERR_CYCLE),
        .FIRST_ERR_FIELD (FIRST_ERR_FIELD),
        .DONE            (DONE),
        .PASS            (PASS)
    );

    initial Clock_50 = 1'b0;
    always #5 Clock_50 = ~Clock_50;

    function automatic logic [RW-1:0] mk_rec(input int s);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) r[i*DW +: DW] = 32'(s * 257 + i * 7);
        r[RW-1] = s[0];
        return r;
    endfunction

    task automatic tick();
        @(posedge Clock_50);
        #1;
    endtask

    // Core 0 gets records base+j, core 1 gets base+100+j.
    task automatic preload(input int n0, input int n1, input int base);
        for (int j = 0; j < 8; j++) begin
            if (j >= n0 && j >= n1) break;
            EXP_VALID = '0;
            EXP_LAST  = '0;
            if (j < n0) begin
                EXP_VALID[0]       = 1'b1;
                EXP_LAST[0]        = (j == n0 - 1);
                EXP_REC[0 +: RW]   = mk_rec(base + j);
            end
            if (j < n1) begin
                EXP_VALID[1]       = 1'b1;
                EXP_LAST[1]        = (j == n1 - 1);
                EXP_REC[RW +: RW]  = mk_rec(base + 100 + j);
            end
            tick();
        end
        EXP_VALID = '0;
        EXP_LAST  = '0;
    endtask

    task automatic set_obs(input int j0, input int j1, input int base);
        OBS_REC[0 +: RW]  = mk_rec(base + j0);
        OBS_REC[RW +: RW] = mk_rec(base + 100 + j1);
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0; ABORT = 1'b0;
        EXP_VALID = '0; EXP_LAST = '0; EXP_REC = '0; OBS_REC = '0; OBS_STALL = '0;
        tick(); tick();
        RESET = 1'b0;
        tick();
        checks++; if (EXP_READY !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", EXP_READY); end
        checks++; if (DONE !== 1'b0 || PASS !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b want 0/0", DONE, PASS); end
        checks++; if (CYCLE_COUNT !== '0) begin errors++; $display("FAIL reset_cyc got %h want 0", CYCLE_COUNT); end
        checks++; if (MISMATCH_COUNT !== '0) begin errors++; $display("FAIL reset_mis got %h want 0", MISMATCH_COUNT); end
        checks++; if (UNDERRUN !== 2'b00 || FIRST_ERR_VALID !== 1'b0) begin errors++; $display("FAIL reset_err got %b/%b want 00/0", UNDERRUN, FIRST_ERR_VALID); end
    endtask

    task automatic test_basic();
        preload(3, 3, 10);
        set_obs(0, 0, 10);
        START = 1'b1; tick(); START = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set_obs(j, j, 10);
            tick();
            if (j == 1) begin
                checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b want 0", DONE); end
            end
        end
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", DONE); end
        checks++; if (CYCLE_COUNT !== {16'd3, 16'd3}) begin errors++; $display("FAIL basic_cyc got %h want 00030003", CYCLE_COUNT); end
        checks++; if (MISMATCH_COUNT !== '0) begin errors++; $display("FAIL basic_mis got %h want 0", MISMATCH_COUNT); end
        checks++; if (PASS !== 1'b1) begin errors++; $display("FAIL basic_pass got %b want 1", PASS); end
    endtask

    task automatic test_stall();
        preload(3, 3, 20);
        set_obs(0, 0, 20);
        START = 1'b1; tick(); START = 1'b0;
        // Core 1 stalls on even cycles, so it pops at cycles 1, 3 and 5.
        for (int c = 0; c < 6; c++) begin
            OBS_STALL = (c % 2 == 0) ? 2'b10 : 2'b00;
            set_obs((c > 2) ? 2 : c, c / 2, 20);
            tick();
            if (c == 4) begin
                checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL stall_early_done got %b want 0", DONE); end
                checks++; if (CYCLE_COUNT[CW +: CW] !== 16'd2) begin errors++; $display("FAIL stall_cyc1_mid got %0d want 2", CYCLE_COUNT[CW +: CW]); end
            end
        end
        checks++; if (DONE !== 1'b1 || PASS !== 1'b1) begin errors++; $display("FAIL stall_done got %b/%b want 1/1", DONE, PASS); end
        checks++; if (CYCLE_COUNT !== {16'd3, 16'd3}) begin errors++; $display("FAIL stall_cyc got %h want 00030003", CYCLE_COUNT); end
        OBS_STALL = 2'b00;
        tick();
        checks++; if (CYCLE_COUNT[CW +: CW] !== 16'd3) begin errors++; $display("FAIL stall_cyc1_hold got %0d want 3", CYCLE_COUNT[CW +: CW]); end
    endtask

    task automatic test_mismatch();
        preload(3, 3, 30);
        set_obs(0, 0, 30);
        START = 1'b1; tick(); START = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set_obs(j, j, 30);
            if (j == 2) begin
                OBS_REC[11*DW +: DW]     = OBS_REC[11*DW +: DW] + 32'd1;
                OBS_REC[RW + DW +: DW]   = OBS_REC[RW + DW +: DW] ^ 32'd1;
            end
            tick();
        end
        checks++; if (FIRST_ERR_VALID !== 1'b1) begin errors++; $display("FAIL mis_fe_valid got %b want 1", FIRST_ERR_VALID); end
        checks++; if (FIRST_ERR_CORE !== 3'd0) begin errors++; $display("FAIL mis_fe_core got %0d want 0", FIRST_ERR_CORE); end
        checks++; if (FIRST_ERR_CYCLE !== 16'd2) begin errors++; $display("FAIL mis_fe_cycle got %0d want 2", FIRST_ERR_CYCLE); end
        checks++; if (FIRST_ERR_FIELD !== 4'd11) begin errors++; $display("FAIL mis_fe_field got %0d want 11", FIRST_ERR_FIELD); end
        checks++; if (MISMATCH_COUNT !== {16'd1, 16'd1}) begin errors++; $display("FAIL mis_count got %h want 00010001", MISMATCH_COUNT); end
        checks++; if (DONE !== 1'b1 || PASS !== 1'b0) begin errors++; $display("FAIL mis_pass got %b/%b want 1/0", DONE, PASS); end
    endtask

    task automatic test_full();
        preload(8, 0, 50);
        checks++; if (EXP_READY !== 2'b10) begin errors++; $display("FAIL full_ready got %b want 10", EXP_READY); end
        OBS_STALL = 2'b10;
        set_obs(0, 0, 50);
        START = 1'b1; tick(); START = 1'b0;
        // Ninth push coincides with a pop and must be refused.
        EXP_VALID = 2'b01; EXP_LAST = 2'b00; EXP_REC[0 +: RW] = mk_rec(999);
        tick();
        EXP_VALID = 2'b00;
        OBS_STALL = 2'b11;
        checks++; if (EXP_READY[0] !== 1'b1) begin errors++; $display("FAIL full_after_pop got %b want 1", EXP_READY[0]); end
        checks++; if (CYCLE_COUNT[0 +: CW] !== 16'd1 || MISMATCH_COUNT[0 +: CW] !== 16'd0) begin errors++; $display("FAIL full_pop_cnt got %0d/%0d want 1/0", CYCLE_COUNT[0 +: CW], MISMATCH_COUNT[0 +: CW]); end
        EXP_VALID = 2'b01;
        tick();
        EXP_VALID = 2'b00;
        checks++; if (EXP_READY[0] !== 1'b0) begin errors++; $display("FAIL full_refill got %b want 0", EXP_READY[0]); end
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        OBS_STALL = 2'b00;
        checks++; if (EXP_READY !== 2'b11 || DONE !== 1'b0) begin errors++; $display("FAIL full_abort got %b/%b want 11/0", EXP_READY, DONE); end
    endtask

    task automatic test_underrun();
        preload(3, 0, 70);
        set_obs(0, 0, 70);
        START = 1'b1; tick(); START = 1'b0;
        tick();
        checks++; if (UNDERRUN !== 2'b10) begin errors++; $display("FAIL und_flag got %b want 10", UNDERRUN); end
        checks++; if (FIRST_ERR_VALID !== 1'b1 || FIRST_ERR_CORE !== 3'd1) begin errors++; $display("FAIL und_fe_core got %b/%0d want 1/1", FIRST_ERR_VALID, FIRST_ERR_CORE); end
        checks++; if (FIRST_ERR_FIELD !== 4'd15 || FIRST_ERR_CYCLE !== 16'd0) begin errors++; $display("FAIL und_fe_field got %0d/%0d want 15/0", FIRST_ERR_FIELD, FIRST_ERR_CYCLE); end
        checks++; if (CYCLE_COUNT !== {16'd0, 16'd1}) begin errors++; $display("FAIL und_cyc got %h want 00000001", CYCLE_COUNT); end
        checks++; if (MISMATCH_COUNT !== {16'd1, 16'd0}) begin errors++; $display("FAIL und_mis got %h want 00010000", MISMATCH_COUNT); end
        ABORT = 1'b1; tick(); ABORT = 1'b0;
    endtask

    task automatic test_abort();
        preload(5, 5, 90);
        set_obs(0, 0, 90);
        START = 1'b1; tick(); START = 1'b0;
        set_obs(0, 0, 90); tick();
        set_obs(1, 1, 90); tick();
        ABORT = 1'b1; START = 1'b1; tick(); ABORT = 1'b0; START = 1'b0;
        checks++; if (DONE !== 1'b0 || EXP_READY !== 2'b11) begin errors++; $display("FAIL abort_state got %b/%b want 0/11", DONE, EXP_READY); end
        checks++; if (CYCLE_COUNT !== {16'd2, 16'd2}) begin errors++; $display("FAIL abort_cyc got %h want 00020002", CYCLE_COUNT); end
        checks++; if (FIRST_ERR_VALID !== 1'b0) begin errors++; $display("FAIL abort_fe got %b want 0", FIRST_ERR_VALID); end
        // A fresh run with no preload proves both FIFOs were flushed.
        START = 1'b1; tick(); START = 1'b0;
        tick();
        checks++; if (UNDERRUN !== 2'b11) begin errors++; $display("FAIL abort_flushed got %b want 11", UNDERRUN); end
        checks++; if (FIRST_ERR_CORE !== 3'd0 || FIRST_ERR_FIELD !== 4'd15) begin errors++; $display("FAIL abort_fe_core got %0d/%0d want 0/15", FIRST_ERR_CORE, FIRST_ERR_FIELD); end
        ABORT = 1'b1; tick(); ABORT = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_mismatch();
        test_full();
        test_underrun();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
